// File: rtl/rc5_pkg.sv
// rc5_pkg: shared definitions for the RC5-w/r cipher core.
//   - rc5_state_e   : controller states (IDLE, PRE, ROUND, POST, DONE)
//   - RC5_LGW_DEFAULT / lg_w() : rotation-amount width for a given word width
//   - rotl / rotr   : word rotations for any w in {16, 32, 64}, carried in 64 bits
//   - RC5_DEFAULT_KEY : team default 26-entry 32-bit expanded key table
package rc5_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRE   = 3'd1,
    ROUND = 3'd2,
    POST  = 3'd3,
    DONE  = 3'd4
  } rc5_state_e;

  localparam int RC5_LGW_DEFAULT = 5;

  function automatic int lg_w(input int w);
    return $clog2(w);
  endfunction

  // Operands live in the low w bits of a 64-bit carrier. A zero amount
  // shifts the wrap-around term fully out, so the operand comes back unchanged.
  function automatic logic [63:0] rotl(input logic [63:0] x, input int amt, input int w);
    logic [63:0] m;
    m = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return (((x & m) << amt) | ((x & m) >> (w - amt))) & m;
  endfunction

  function automatic logic [63:0] rotr(input logic [63:0] x, input int amt, input int w);
    logic [63:0] m;
    m = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return (((x & m) >> amt) | ((x & m) << (w - amt))) & m;
  endfunction

  localparam logic [31:0] RC5_DEFAULT_KEY [26] = '{
    32'h9BBBD8C8, 32'h1A37F7FB, 32'h46F8E8C5, 32'h460C6085,
    32'h70F83B8A, 32'h284B8303, 32'h513E1454, 32'hF621ED22,
    32'h3125065D, 32'h11A83A5D, 32'hD427686B, 32'h713AD82D,
    32'h4B792F99, 32'h2799A4DD, 32'hA7901C49, 32'hDEDE871A,
    32'h36C03196, 32'hA7EFC249, 32'h61A78BB8, 32'h3B0A1D2B,
    32'h4DBFCA76, 32'hAE162167, 32'h30D76B0A, 32'h43192304,
    32'hF6CC1431, 32'h65046380
  };

endpackage

// File: rtl/rc5_cipher_core_key_ram.sv
// rc5_key_ram: NKEY x W expanded-key register file, no reset (contents survive clr).
//   clk_i               : write clock
//   we_i/waddr_i/wdata_i: synchronous write port (caller qualifies we_i)
//   raddr0_i/rdata0_o   : combinational read port, even key S[2i]
//   raddr1_i/rdata1_o   : combinational read port, odd key S[2i+1]
module rc5_key_ram #(
  parameter int W    = 32,
  parameter int NKEY = 26,
  parameter int AW   = $clog2(NKEY)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr0_i,
  input  logic [AW-1:0] raddr1_i,
  output logic [W-1:0]  rdata0_o,
  output logic [W-1:0]  rdata1_o
);

  logic [W-1:0] mem_q [NKEY];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata0_o = mem_q[raddr0_i];
  assign rdata1_o = mem_q[raddr1_i];

endmodule

// File: rtl/rc5_cipher_core.sv
// rc5_cipher_core: RC5-W/ROUNDS encrypt/decrypt core, one round per clock.
//   clk, clr (async, active-high)
//   mode (0 enc, 1 dec), din {A,B}, di_vld/di_rdy : input handshake
//   dout {A,B}, do_vld/do_rdy                       : output handshake
//   key_we/key_addr/key_data                        : expanded-key table write (IDLE only)
//   busy                                            : state != IDLE
//
// state | meaning
// IDLE  | waiting for an input block, key writes allowed
// PRE   | key whitening (encrypt) or round-index setup (decrypt)
// ROUND | one RC5 round per cycle, ROUNDS cycles
// POST  | final whitening removal (decrypt), register result
// DONE  | result held until downstream accepts
module rc5_cipher_core
  import rc5_pkg::*;
#(
  parameter int W      = 32,
  parameter int ROUNDS = 12,
  parameter int NKEY   = 2*ROUNDS+2
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic                    mode,
  input  logic [2*W-1:0]          din,
  input  logic                    di_vld,
  output logic                    di_rdy,
  output logic [2*W-1:0]          dout,
  output logic                    do_vld,
  input  logic                    do_rdy,
  input  logic                    key_we,
  input  logic [$clog2(NKEY)-1:0] key_addr,
  input  logic [W-1:0]            key_data,
  output logic                    busy
);

  localparam int LGW = $clog2(W);
  localparam int AW  = $clog2(NKEY);
  localparam int IW  = $clog2(ROUNDS+1);

  rc5_state_e     state_q;
  logic [IW-1:0]  i_q;
  logic [W-1:0]   a_q, b_q;
  logic           mode_q;
  logic [2*W-1:0] dout_q;
  logic           do_vld_q;

  logic [AW-1:0]  rd_idx, addr_even, addr_odd;
  logic [W-1:0]   s_even, s_odd;
  logic [W-1:0]   enc_a, enc_b, dec_a, dec_b;
  logic [W-1:0]   a_rnd_d, b_rnd_d, a_post_d, b_post_d;
  logic [IW-1:0]  i_last;
  logic           key_wr;

  function automatic logic [W-1:0] rol_w(input logic [W-1:0] x, input logic [LGW-1:0] n);
    logic [63:0] t;
    t = rotl(64'(x), int'(n), W);
    return t[W-1:0];
  endfunction

  function automatic logic [W-1:0] ror_w(input logic [W-1:0] x, input logic [LGW-1:0] n);
    logic [63:0] t;
    t = rotr(64'(x), int'(n), W);
    return t[W-1:0];
  endfunction

  // Outside ROUND the read ports sit on S[0]/S[1] for PRE and POST whitening.
  always_comb begin
    rd_idx    = (state_q == ROUND) ? AW'(i_q) : '0;
    addr_even = rd_idx << 1;
    addr_odd  = addr_even | AW'(1);
  end

  assign key_wr = key_we & (state_q == IDLE) & (int'(key_addr) < NKEY);

  rc5_key_ram #(.W(W), .NKEY(NKEY), .AW(AW)) u_key_ram (
    .clk_i    (clk),
    .we_i     (key_wr),
    .waddr_i  (key_addr),
    .wdata_i  (key_data),
    .raddr0_i (addr_even),
    .raddr1_i (addr_odd),
    .rdata0_o (s_even),
    .rdata1_o (s_odd)
  );

  always_comb begin
    enc_a    = rol_w(a_q ^ b_q, b_q[LGW-1:0]) + s_even;
    enc_b    = rol_w(b_q ^ enc_a, enc_a[LGW-1:0]) + s_odd;
    dec_b    = ror_w(b_q - s_odd, a_q[LGW-1:0]) ^ a_q;
    dec_a    = ror_w(a_q - s_even, dec_b[LGW-1:0]) ^ dec_b;
    a_rnd_d  = mode_q ? dec_a : enc_a;
    b_rnd_d  = mode_q ? dec_b : enc_b;
    a_post_d = mode_q ? (a_q - s_even) : a_q;
    b_post_d = mode_q ? (b_q - s_odd) : b_q;
    i_last   = mode_q ? IW'(1) : IW'(ROUNDS);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q  <= IDLE;
      i_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      mode_q   <= 1'b0;
      dout_q   <= '0;
      do_vld_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (di_vld) begin
            a_q     <= din[2*W-1:W];
            b_q     <= din[W-1:0];
            mode_q  <= mode;
            state_q <= PRE;
          end
        end
        PRE: begin
          if (!mode_q) begin
            a_q <= a_q + s_even;
            b_q <= b_q + s_odd;
            i_q <= IW'(1);
          end else begin
            i_q <= IW'(ROUNDS);
          end
          state_q <= ROUND;
        end
        ROUND: begin
          a_q <= a_rnd_d;
          b_q <= b_rnd_d;
          if (i_q == i_last) state_q <= POST;
          else if (mode_q)   i_q <= i_q - IW'(1);
          else               i_q <= i_q + IW'(1);
        end
        POST: begin
          a_q      <= a_post_d;
          b_q      <= b_post_d;
          dout_q   <= {a_post_d, b_post_d};
          do_vld_q <= 1'b1;
          state_q  <= DONE;
        end
        DONE: begin
          if (do_rdy) begin
            do_vld_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign di_rdy = (state_q == IDLE) & ~clr;
  assign busy   = (state_q != IDLE);
  assign dout   = dout_q;
  assign do_vld = do_vld_q;

endmodule
